mad_io_peripheral: RTL and testbench
====================================

// Module: mad_io_peripheral
// PURPOSE
// Device-side endpoint of the processor's In/Out/Int port interface: drives the In port and Int line, consumes the Out port.
// Host writes go through a valid/ready handshake into an input FIFO whose head word is driven on ProcIn.
// An interrupt pulse is raised per pending word; the processor's IN-retire strobe pops the word.
// Processor OUT writes are queued in an output FIFO drained by the host via valid/ready.
// PARAMETERS
// DATA_W     16  port word width
// IN_DEPTH   4   input FIFO entries (power of 2, >=2)
// OUT_DEPTH  4   output FIFO entries (power of 2, >=2)
// CNT_W      3   occupancy counter width, must hold 0..max(IN_DEPTH,OUT_DEPTH)
// INT_PULSE  1   Int high time in cycles (>=1)
// PORTS
// Clk        in   1       clock, all state on rising edge
// Rst        in   1       synchronous reset, active-low
// HostInData in  DATA_W   host word to processor
// HostInVld  in   1       host word valid
// HostInRdy  out  1       input FIFO can accept (= in_count < IN_DEPTH)
// ProcIn     out  DATA_W  to processor In port: head of input FIFO, 0 when empty
// ProcInAck  in   1       processor retired an IN instruction; pops head
// Int        out  1       interrupt to processor, registered
// IntEn      in   1       interrupt enable
// ProcOut    in   DATA_W  processor Out port value
// ProcOutWe  in   1       processor retired an OUT instruction this cycle
// HostOutData out DATA_W  head of output FIFO, 0 when empty
// HostOutVld out  1       output FIFO non-empty
// HostOutRdy in   1       host takes HostOutData
// InCount    out  CNT_W   input FIFO occupancy
// OutOvf     out  1       sticky: ProcOutWe dropped while output FIFO full
// OvfClr     in   1       clears OutOvf
// BEHAVIOUR
// - Reset (Rst=0 at edge): both FIFOs empty, pointers 0, FSM=IDLE, Int=0, OutOvf=0; all outputs 0 except HostInRdy=1.
// - Reset takes priority over every other input in the same cycle; mid-pulse or mid-queue contents are discarded.
// - FIFOs are first-word-fall-through.
//   - A word pushed at edge k appears on ProcIn/HostOutData after edge k (0-cycle read latency).
// - Input push when HostInVld & HostInRdy.
//   - When full, HostInRdy=0 even if ProcInAck pops that cycle (no push-through-full).
// - ProcInAck with input FIFO empty: ignored, no pointer change, no underflow.
// - Simultaneous push and pop on non-full, non-empty FIFO: count unchanged, both take effect.
// - Pointers wrap modulo depth; count distinguishes full from empty.
// - Output push on ProcOutWe. If full, the word is dropped, FIFO unchanged, OutOvf<=1.
//   - Pop on HostOutVld & HostOutRdy.
//   - A pop in the same cycle as a full-FIFO write does NOT make room: the word is still dropped.
// - OutOvf: set has priority over OvfClr in the same cycle.
// - Interrupt FSM, state registered, Int is a registered output:
//   IDLE:     if IntEn & in_count!=0 -> PULSE (Int=1 from next edge), pulse counter=0.
//   PULSE:    Int=1; after INT_PULSE cycles -> WAIT_ACK, Int=0. IntEn drop does not truncate the pulse.
//   WAIT_ACK: Int=0; on ProcInAck that pops a word -> IDLE.
//             If ProcInAck lands during PULSE, the pop happens and the FSM goes to IDLE once the pulse completes.
// - From IDLE, one Int pulse is issued per word.
//   - After the return to IDLE there is at least one Int=0 cycle before the next pulse.
// - Latency: word accepted at edge k -> Int rises at edge k+2 (IDLE samples non-empty at k+1).
// TESTING
// - Reset: hold Rst=0 2 cycles with HostInVld=1 -> InCount=0, Int=0, HostInRdy=1, ProcIn=0.
// - Push 16'hA5A5, IntEn=1 -> ProcIn=A5A5 one cycle later; Int high exactly 1 cycle at +2; ProcInAck -> ProcIn=0, InCount=0.
// - Push 4 words 1,2,3,4 with no ack -> HostInRdy=0.
//   - Fifth word held with HostInVld=1 and not accepted.
//   - Ack+push in the same cycle while full -> only the pop occurs, InCount=3.
// - IntEn=0, push 2 words -> no Int; raise IntEn -> 2 separate pulses, each followed by ack, with a gap cycle between.
// - HostOutRdy=0, ProcOutWe with 10,11,12,13,14 -> first 4 queued, 14 dropped, OutOvf=1; OvfClr with a new drop same cycle -> OutOvf stays 1.
// - Pipelined traffic: ProcOutWe every cycle with HostOutRdy=1 for 20 words -> HostOutData in order, no loss, OutOvf=0.

Source files
------------

// File: rtl/mad_io_peripheral.sv
// mad_io_peripheral
// Device-side endpoint of the processor In/Out/Int port interface.
//   - Host words enter an input FIFO through a valid/ready handshake. The head
//     word is driven on ProcIn. The processor's IN-retire strobe pops it.
//   - An interrupt FSM raises one registered Int pulse per pending word.
//   - Processor OUT writes are queued in an output FIFO that the host drains
//     through a valid/ready handshake. Writes to a full FIFO are dropped and
//     recorded in a sticky overflow flag.
//
// Handshake rule (both host-side channels): a word moves on a rising edge
// exactly when valid and ready are both high. Ready never depends on the
// matching valid. Valid and data are held until the transfer takes place.
//
// Ports:
//   Clk, Rst       clock; synchronous active-low reset
//   HostInData/Vld host word into the input FIFO; HostInRdy = FIFO not full
//   ProcIn         head of the input FIFO (0 when empty)
//   ProcInAck      processor retired an IN; pops the head if there is one
//   Int, IntEn     registered interrupt pulse and its enable
//   ProcOut/We     processor OUT value and its write strobe
//   HostOutData/Vld/Rdy  output FIFO head, non-empty flag, host take
//   InCount        input FIFO occupancy
//   OutOvf, OvfClr sticky output-overflow flag and its clear
//   DbgIntState    interrupt FSM state (0 idle, 1 pulse, 2 wait-ack)
module mad_io_peripheral #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 3,
  parameter int INT_PULSE = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] HostInData,
  input  logic              HostInVld,
  output logic              HostInRdy,
  output logic [DATA_W-1:0] ProcIn,
  input  logic              ProcInAck,
  output logic              Int,
  input  logic              IntEn,
  input  logic [DATA_W-1:0] ProcOut,
  input  logic              ProcOutWe,
  output logic [DATA_W-1:0] HostOutData,
  output logic              HostOutVld,
  input  logic              HostOutRdy,
  output logic [CNT_W-1:0]  InCount,
  output logic              OutOvf,
  input  logic              OvfClr,
  output logic [1:0]        DbgIntState
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int PCNT_W = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(INT_PULSE - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } int_state_t;

  // ---------------------------------------------------------------- input FIFO
  logic [DATA_W-1:0] r_in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  r_in_wp;
  logic [IN_AW-1:0]  r_in_rp;
  logic [CNT_W-1:0]  r_in_cnt;
  logic              w_in_full;
  logic              w_in_nempty;
  logic              w_in_push;
  logic              w_in_pop;

  assign w_in_full   = (r_in_cnt == CNT_W'(IN_DEPTH));
  assign w_in_nempty = (r_in_cnt != '0);
  // Ready comes from the count only, so a same-cycle pop never opens a full FIFO.
  assign w_in_push   = HostInVld & ~w_in_full;
  assign w_in_pop    = ProcInAck & w_in_nempty;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wp] <= HostInData;
        r_in_wp           <= r_in_wp + 1'b1;
      end
      if (w_in_pop) begin
        r_in_rp <= r_in_rp + 1'b1;
      end
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
        2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  assign HostInRdy = ~w_in_full;
  assign ProcIn    = w_in_nempty ? r_in_mem[r_in_rp] : '0;
  assign InCount   = r_in_cnt;

  // --------------------------------------------------------------- output FIFO
  logic [DATA_W-1:0] r_out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] r_out_wp;
  logic [OUT_AW-1:0] r_out_rp;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_out_ovf;
  logic              w_out_full;
  logic              w_out_nempty;
  logic              w_out_push;
  logic              w_out_drop;
  logic              w_out_pop;

  assign w_out_full   = (r_out_cnt == CNT_W'(OUT_DEPTH));
  assign w_out_nempty = (r_out_cnt != '0);
  // Fullness is judged before any same-cycle host pop: the write is dropped.
  assign w_out_push   = ProcOutWe & ~w_out_full;
  assign w_out_drop   = ProcOutWe & w_out_full;
  assign w_out_pop    = w_out_nempty & HostOutRdy;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wp] <= ProcOut;
        r_out_wp            <= r_out_wp + 1'b1;
      end
      if (w_out_pop) begin
        r_out_rp <= r_out_rp + 1'b1;
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase
      // A new drop wins over a clear in the same cycle.
      if (w_out_drop) begin
        r_out_ovf <= 1'b1;
      end else if (OvfClr) begin
        r_out_ovf <= 1'b0;
      end
    end
  end

  assign HostOutVld  = w_out_nempty;
  assign HostOutData = w_out_nempty ? r_out_mem[r_out_rp] : '0;
  assign OutOvf      = r_out_ovf;

  // ------------------------------------------------------------ interrupt FSM
  int_state_t        r_state;
  int_state_t        w_state_nxt;
  logic [PCNT_W-1:0] r_pcnt;
  logic [PCNT_W-1:0] w_pcnt_nxt;
  logic              r_ack_seen;
  logic              w_ack_seen_nxt;
  logic              r_int;
  logic              w_int_nxt;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= ST_IDLE;
      r_pcnt     <= '0;
      r_ack_seen <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_ack_seen <= w_ack_seen_nxt;
      r_int      <= w_int_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pcnt_nxt     = r_pcnt;
    w_ack_seen_nxt = r_ack_seen;
    // Int lags the PULSE state by one edge. A word accepted at edge k is seen
    // by IDLE at k+1, and Int rises at k+2.
    w_int_nxt      = (r_state == ST_PULSE);
    case (r_state)
      ST_IDLE: begin
        if (IntEn && w_in_nempty) begin
          w_state_nxt    = ST_PULSE;
          w_pcnt_nxt     = '0;
          w_ack_seen_nxt = 1'b0;
        end
      end
      ST_PULSE: begin
        // IntEn is not looked at here, so the pulse always runs to full length.
        // An ack that lands inside the pulse is remembered so that the FSM
        // skips the wait for an ack.
        if (w_in_pop) begin
          w_ack_seen_nxt = 1'b1;
        end
        if (r_pcnt == PCNT_LAST) begin
          w_state_nxt = (r_ack_seen || w_in_pop) ? ST_IDLE : ST_WAIT_ACK;
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (w_in_pop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign Int         = r_int;
  assign DbgIntState = r_state;

endmodule

// File: tb/tb_mad_io_peripheral.sv
module tb_mad_io_peripheral;

  // ------------------------------------------------------------ clock / reset
  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] HostInData;
  logic        HostInVld;
  logic        HostInRdy;
  logic [15:0] ProcIn;
  logic        ProcInAck;
  logic        Int;
  logic        IntEn;
  logic [15:0] ProcOut;
  logic        ProcOutWe;
  logic [15:0] HostOutData;
  logic        HostOutVld;
  logic        HostOutRdy;
  logic [2:0]  InCount;
  logic        OutOvf;
  logic        OvfClr;
  logic [1:0]  DbgIntState;

  always #5 Clk = ~Clk;

  mad_io_peripheral #(
    .DATA_W(16), .IN_DEPTH(4), .OUT_DEPTH(4), .CNT_W(3), .INT_PULSE(1)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .HostInData(HostInData), .HostInVld(HostInVld), .HostInRdy(HostInRdy),
    .ProcIn(ProcIn), .ProcInAck(ProcInAck),
    .Int(Int), .IntEn(IntEn),
    .ProcOut(ProcOut), .ProcOutWe(ProcOutWe),
    .HostOutData(HostOutData), .HostOutVld(HostOutVld), .HostOutRdy(HostOutRdy),
    .InCount(InCount), .OutOvf(OutOvf), .OvfClr(OvfClr),
    .DbgIntState(DbgIntState)
  );

  // ------------------------------------------------------------ scoreboard
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_rx;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  // Inputs change 1 time unit after each rising edge, and outputs are read there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ------------------------------------------------------------ directed steps
  initial begin
    Rst = 1'b0; HostInData = 16'hFFFF; HostInVld = 1'b1; ProcInAck = 1'b0;
    IntEn = 1'b0; ProcOut = '0; ProcOutWe = 1'b0; HostOutRdy = 1'b0; OvfClr = 1'b0;

    // Reset held 2 cycles with a host word pending.
    tick(); tick();
    check("rst_incount", 32'(InCount), 32'd0);
    check("rst_int", 32'(Int), 32'd0);
    check("rst_hostinrdy", 32'(HostInRdy), 32'd1);
    check("rst_procin", 32'(ProcIn), 32'd0);
    check("rst_hostoutvld", 32'(HostOutVld), 32'd0);
    check("rst_outovf", 32'(OutOvf), 32'd0);
    check("rst_state", 32'(DbgIntState), 32'd0);
    Rst = 1'b1; HostInVld = 1'b0;

    // One word with interrupts enabled.
    IntEn = 1'b1; HostInData = 16'hA5A5; HostInVld = 1'b1;
    tick(); HostInVld = 1'b0;                        // edge k
    check("one_procin", 32'(ProcIn), 32'h0000A5A5);
    check("one_incount", 32'(InCount), 32'd1);
    check("one_int_k", 32'(Int), 32'd0);
    tick();                                          // k+1
    check("one_int_k1", 32'(Int), 32'd0);
    check("one_state_pulse", 32'(DbgIntState), 32'd1);
    tick();                                          // k+2
    check("one_int_k2", 32'(Int), 32'd1);
    tick();                                          // k+3
    check("one_int_k3", 32'(Int), 32'd0);
    check("one_state_wait", 32'(DbgIntState), 32'd2);
    ProcInAck = 1'b1; tick(); ProcInAck = 1'b0;
    check("one_ack_procin", 32'(ProcIn), 32'd0);
    check("one_ack_incount", 32'(InCount), 32'd0);
    check("one_ack_state", 32'(DbgIntState), 32'd0);
    tick();
    check("one_idle_int", 32'(Int), 32'd0);

    // An ack that lands during the pulse returns to IDLE with no wait-ack.
    HostInData = 16'h1234; HostInVld = 1'b1;
    tick(); HostInVld = 1'b0;                        // edge k
    tick();                                          // k+1, PULSE
    ProcInAck = 1'b1; tick(); ProcInAck = 1'b0;      // k+2
    check("pack_int", 32'(Int), 32'd1);
    check("pack_incount", 32'(InCount), 32'd0);
    check("pack_state", 32'(DbgIntState), 32'd0);
    tick();
    check("pack_int_after", 32'(Int), 32'd0);
    check("pack_state_after", 32'(DbgIntState), 32'd0);
    IntEn = 1'b0;

    // Fill the input FIFO, then hold a fifth word.
    for (int i = 1; i <= 4; i++) begin
      HostInData = 16'(i); HostInVld = 1'b1; tick();
    end
    check("full_incount", 32'(InCount), 32'd4);
    check("full_rdy", 32'(HostInRdy), 32'd0);
    check("full_procin", 32'(ProcIn), 32'd1);
    HostInData = 16'd5; tick();
    check("full_hold_incount", 32'(InCount), 32'd4);
    check("full_hold_procin", 32'(ProcIn), 32'd1);
    ProcInAck = 1'b1; tick(); ProcInAck = 1'b0; HostInVld = 1'b0;
    check("full_ackpush_incount", 32'(InCount), 32'd3);
    check("full_ackpush_procin", 32'(ProcIn), 32'd2);
    check("full_ackpush_rdy", 32'(HostInRdy), 32'd1);
    ProcInAck = 1'b1;
    tick(); check("drain_procin_3", 32'(ProcIn), 32'd3);
    tick(); check("drain_procin_4", 32'(ProcIn), 32'd4);
    tick(); check("drain_procin_0", 32'(ProcIn), 32'd0);
    tick();                                          // ack on an empty FIFO
    check("empty_ack_incount", 32'(InCount), 32'd0);
    check("empty_ack_procin", 32'(ProcIn), 32'd0);
    ProcInAck = 1'b0;

    // Two words while disabled, then one pulse per word.
    HostInData = 16'h0B0B; HostInVld = 1'b1; tick();
    HostInData = 16'h0C0C; tick(); HostInVld = 1'b0;
    tick(); tick();
    check("dis_int", 32'(Int), 32'd0);
    check("dis_incount", 32'(InCount), 32'd2);
    check("dis_procin", 32'(ProcIn), 32'h00000B0B);
    IntEn = 1'b1;
    tick(); check("two_e1_int", 32'(Int), 32'd0);
    tick(); check("two_e2_int", 32'(Int), 32'd1);
    tick(); check("two_e3_int", 32'(Int), 32'd0);
    ProcInAck = 1'b1; tick(); ProcInAck = 1'b0;
    check("two_e4_procin", 32'(ProcIn), 32'h00000C0C);
    check("two_e4_incount", 32'(InCount), 32'd1);
    check("two_e4_int", 32'(Int), 32'd0);
    tick(); check("two_e5_gap", 32'(Int), 32'd0);
    tick(); check("two_e6_int", 32'(Int), 32'd1);
    tick(); check("two_e7_int", 32'(Int), 32'd0);
    ProcInAck = 1'b1; tick(); ProcInAck = 1'b0;
    check("two_e8_incount", 32'(InCount), 32'd0);
    tick();
    check("two_e9_int", 32'(Int), 32'd0);
    check("two_e9_state", 32'(DbgIntState), 32'd0);
    IntEn = 1'b0;

    // Reset in the middle of the queue discards the contents.
    HostInData = 16'h7777; HostInVld = 1'b1; tick(); HostInVld = 1'b0;
    Rst = 1'b0; tick(); Rst = 1'b1;
    check("midrst_incount", 32'(InCount), 32'd0);
    check("midrst_procin", 32'(ProcIn), 32'd0);

    // Output FIFO overflow with the host stalled.
    HostOutRdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ProcOut = 16'(10 + i); ProcOutWe = 1'b1; tick();
      if (i == 3) begin
        check("ovf_vld4", 32'(HostOutVld), 32'd1);
        check("ovf_data4", 32'(HostOutData), 32'd10);
        check("ovf_flag4", 32'(OutOvf), 32'd0);
      end
    end
    check("ovf_flag5", 32'(OutOvf), 32'd1);
    check("ovf_head5", 32'(HostOutData), 32'd10);
    OvfClr = 1'b1; ProcOut = 16'd15; tick();
    check("ovf_set_beats_clr", 32'(OutOvf), 32'd1);
    OvfClr = 1'b0; HostOutRdy = 1'b1; ProcOut = 16'd16; tick();
    ProcOutWe = 1'b0; HostOutRdy = 1'b0;
    check("ovf_pop_no_room_head", 32'(HostOutData), 32'd11);
    check("ovf_pop_no_room_flag", 32'(OutOvf), 32'd1);
    OvfClr = 1'b1; tick(); OvfClr = 1'b0;
    check("ovf_clr", 32'(OutOvf), 32'd0);
    HostOutRdy = 1'b1;
    tick(); check("odrain_12", 32'(HostOutData), 32'd12);
    tick(); check("odrain_13", 32'(HostOutData), 32'd13);
    tick();
    check("odrain_vld0", 32'(HostOutVld), 32'd0);
    check("odrain_data0", 32'(HostOutData), 32'd0);

    // Pipelined output traffic: one write per cycle with the host always ready.
    exp_q.delete();
    n_rx = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) begin
        ProcOutWe = 1'b1; ProcOut = 16'(16'h0100 + c);
      end else begin
        ProcOutWe = 1'b0;
      end
      if (HostOutVld) begin
        if (exp_q.size() != 0) exp_word = exp_q.pop_front();
        else exp_word = 16'hDEAD;
        check("pipe_data", 32'(HostOutData), 32'(exp_word));
        n_rx++;
      end
      tick();
      if (c < 20) exp_q.push_back(ProcOut);
    end
    check("pipe_count", 32'(n_rx), 32'd20);
    check("pipe_left", 32'(exp_q.size()), 32'd0);
    check("pipe_ovf", 32'(OutOvf), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
